pipe_hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32 core.
- Detects load-use hazards, redirect flushes and multi-cycle execute operations such as CLZ/CTZ/CPOP iterative units or a future MUL/DIV.
- Drives the stall and flush controls consumed by fetch, decode and execute.
- Owns a small FSM so that multi-cycle stalls and flush windows are sequenced rather than decoded ad hoc in each stage.

---
 rtl/pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central pipeline sequencer for the 5-stage RV32 core. It watches for
// load-use hazards, redirect flushes and multi-cycle execute operations.
// From these it drives the stall and flush controls seen by fetch, decode
// and execute. A small FSM sequences multi-cycle stalls and flush windows,
// so the individual stages do not decode them ad hoc.
//
// Parameters:
//   FLUSH_CYCLES      cycles flushD_o/flushE_o stay high after a redirect (1..15)
//   LOAD_STALL_CYCLES bubble cycles inserted per load-use hazard (1..3)
//   MC_TIMEOUT        max cycles spent in MC_WAIT before a forced abort (2..1023)
//   CNT_W             width of the optional performance counters
//
// Ports:
//   clk_i, rstn_i              clock, asynchronous active-low reset
//   rs1D_addr_i, rs2D_addr_i   decode-stage source register indices
//   rs1D_used_i, rs2D_used_i   decode instruction actually reads rs1/rs2
//   rdE_addr_i, rdE_wrt_ena_i  execute-stage destination and write enable
//   loadE_i                    execute-stage instruction is a load
//   redirect_i                 registered next-PC enable from EX/MEM
//   mc_req_i, mc_done_i        multi-cycle op present / result valid
//   stallF_o, stallD_o, stallE_o  hold PC, IF/ID, ID/EX
//   flushD_o, flushE_o         squash IF/ID, squash ID/EX (bubble)
//   mc_abort_o                 one-cycle pulse cancelling the multi-cycle unit
//   timeout_o                  sticky multi-cycle timeout flag
//   state_o                    current FSM state (RUN=0 LSTALL=1 FLUSH=2 MC_WAIT=3)
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   stall_cnt_o, flush_cnt_o, mc_cnt_o saturating performance counters.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES      = 2,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MC_TIMEOUT        = 64,
   parameter int CNT_W             = 32
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic [4:0]       rs1D_addr_i,
   input  logic [4:0]       rs2D_addr_i,
   input  logic             rs1D_used_i,
   input  logic             rs2D_used_i,
   input  logic [4:0]       rdE_addr_i,
   input  logic             rdE_wrt_ena_i,
   input  logic             loadE_i,
   input  logic             redirect_i,
   input  logic             mc_req_i,
   input  logic             mc_done_i,
   output logic             stallF_o,
   output logic             stallD_o,
   output logic             stallE_o,
   output logic             flushD_o,
   output logic             flushE_o,
   output logic             mc_abort_o,
   output logic             timeout_o,
   output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] mc_cnt_o
`endif
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LSTALL  = 2'd1,
      FLUSH   = 2'd2,
      MC_WAIT = 2'd3
   } state_t;

   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_STALL_CYCLES - 1);
   localparam logic [9:0] TIMEOUT_LIM  = 10'(MC_TIMEOUT);
   // A single-cycle flush window needs no FLUSH state at all.
   localparam state_t     REDIR_STATE  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic [9:0] tcnt;
   logic [9:0] tcnt_nxt;
   logic       timeout_q;
   logic       timeout_set;
   logic       hit;
   logic       stall_f;
   logic       stall_d;
   logic       stall_e;
   logic       flush_d;
   logic       flush_e;
   logic       abort;

   // Load-use hazard: the load in execute writes a register that the
   // instruction in decode reads. Writes to x0 never create a dependency.
   always_comb begin
      hit = loadE_i && rdE_wrt_ena_i && (rdE_addr_i != 5'd0) &&
            ((rs1D_used_i && (rs1D_addr_i == rdE_addr_i)) ||
             (rs2D_used_i && (rs2D_addr_i == rdE_addr_i)));
   end

   // State, window counter, timeout counter and sticky timeout flag.
   // The timeout flag only clears on reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= RUN;
         cnt       <= 4'd0;
         tcnt      <= 10'd0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         tcnt  <= tcnt_nxt;
         if (timeout_set) begin
            timeout_q <= 1'b1;
         end
      end
   end

   // Next-state and control decode. A redirect beats everything in every
   // state. A multi-cycle op comes next, and a load-use hit comes last.
   // The flush window and the load-stall window count down. They return
   // to RUN in the cycle where the counter reads 1, and that cycle still
   // asserts its controls. In MC_WAIT, a done in the timeout cycle wins,
   // so a result that arrives just in time is never thrown away.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      tcnt_nxt    = tcnt;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      abort       = 1'b0;
      timeout_set = 1'b0;

      case (state)
         RUN: begin
            if (redirect_i) begin
               flush_d   = 1'b1;
               flush_e   = 1'b1;
               state_nxt = REDIR_STATE;
               cnt_nxt   = FLUSH_RELOAD;
            end else if (mc_req_i && !mc_done_i) begin
               stall_f   = 1'b1;
               stall_d   = 1'b1;
               stall_e   = 1'b1;
               state_nxt = MC_WAIT;
               tcnt_nxt  = 10'd1;
            end else if (mc_req_i) begin
               state_nxt = RUN;
            end else if (hit) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  state_nxt = LSTALL;
                  cnt_nxt   = LOAD_RELOAD;
               end
            end
         end

         LSTALL: begin
            if (redirect_i) begin
               flush_d   = 1'b1;
               flush_e   = 1'b1;
               state_nxt = REDIR_STATE;
               cnt_nxt   = FLUSH_RELOAD;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
               if (cnt <= 4'd1) begin
                  state_nxt = RUN;
                  cnt_nxt   = 4'd0;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
         end

         FLUSH: begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (redirect_i) begin
               state_nxt = REDIR_STATE;
               cnt_nxt   = FLUSH_RELOAD;
            end else if (cnt <= 4'd1) begin
               state_nxt = RUN;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end

         MC_WAIT: begin
            if (redirect_i) begin
               abort     = 1'b1;
               flush_d   = 1'b1;
               flush_e   = 1'b1;
               state_nxt = REDIR_STATE;
               cnt_nxt   = FLUSH_RELOAD;
            end else if (mc_done_i) begin
               state_nxt = RUN;
            end else if (tcnt >= TIMEOUT_LIM) begin
               abort       = 1'b1;
               timeout_set = 1'b1;
               flush_e     = 1'b1;
               state_nxt   = RUN;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               if (tcnt != 10'h3FF) begin
                  tcnt_nxt = tcnt + 10'd1;
               end
            end
         end

         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // The outputs are gated with the reset, so the combinational Mealy
   // terms also drop the moment reset asserts. The timeout flag shows up
   // in the same cycle as its abort pulse.
   always_comb begin
      stallF_o   = rstn_i & stall_f;
      stallD_o   = rstn_i & stall_d;
      stallE_o   = rstn_i & stall_e;
      flushD_o   = rstn_i & flush_d;
      flushE_o   = rstn_i & flush_e;
      mc_abort_o = rstn_i & abort;
      timeout_o  = rstn_i & (timeout_q | timeout_set);
      state_o    = rstn_i ? 2'(state) : 2'b00;
   end

`ifdef HAZARD_PERF_CNT_EN
   // Performance counters saturate at all-ones. Every state accepts a
   // redirect, so each redirect cycle counts as one accepted redirect.
   // A multi-cycle entry is the RUN to MC_WAIT transition.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
         mc_cnt_o    <= '0;
      end else begin
         if (stall_d && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
         end
         if (redirect_i && (flush_cnt_o != '1)) begin
            flush_cnt_o <= flush_cnt_o + 1'b1;
         end
         if ((state == RUN) && (state_nxt == MC_WAIT) && (mc_cnt_o != '1)) begin
            mc_cnt_o <= mc_cnt_o + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. The DUT uses FLUSH_CYCLES=2,
// LOAD_STALL_CYCLES=1 and MC_TIMEOUT=8. For each cycle, the expected
// output vector is queued when the inputs are driven. It is popped and
// compared at the following negative edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic [4:0] rs1D_addr_i;
   logic [4:0] rs2D_addr_i;
   logic       rs1D_used_i;
   logic       rs2D_used_i;
   logic [4:0] rdE_addr_i;
   logic       rdE_wrt_ena_i;
   logic       loadE_i;
   logic       redirect_i;
   logic       mc_req_i;
   logic       mc_done_i;
   logic       stallF_o;
   logic       stallD_o;
   logic       stallE_o;
   logic       flushD_o;
   logic       flushE_o;
   logic       mc_abort_o;
   logic       timeout_o;
   logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
   logic [31:0] mc_cnt_o;
`endif

   typedef struct {
      string      tag;
      logic [8:0] vec;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   logic to_exp   = 1'b0;

   pipe_hazard_ctrl #(
      .FLUSH_CYCLES      (2),
      .LOAD_STALL_CYCLES (1),
      .MC_TIMEOUT        (8),
      .CNT_W             (32)
   ) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .rs1D_addr_i   (rs1D_addr_i),
      .rs2D_addr_i   (rs2D_addr_i),
      .rs1D_used_i   (rs1D_used_i),
      .rs2D_used_i   (rs2D_used_i),
      .rdE_addr_i    (rdE_addr_i),
      .rdE_wrt_ena_i (rdE_wrt_ena_i),
      .loadE_i       (loadE_i),
      .redirect_i    (redirect_i),
      .mc_req_i      (mc_req_i),
      .mc_done_i     (mc_done_i),
      .stallF_o      (stallF_o),
      .stallD_o      (stallD_o),
      .stallE_o      (stallE_o),
      .flushD_o      (flushD_o),
      .flushE_o      (flushE_o),
      .mc_abort_o    (mc_abort_o),
      .timeout_o     (timeout_o),
      .state_o       (state_o)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o),
      .mc_cnt_o      (mc_cnt_o)
`endif
   );

   // Free-running core clock with a 10-unit period.
   always #5 clk_i = ~clk_i;

   // Builds the expected output vector in the order
   // {stallF, stallD, stallE, flushD, flushE, abort, timeout, state}.
   function automatic logic [8:0] mk(input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic ab,
                                     input logic to, input logic [1:0] st);
      return {sf, sd, se, fd, fe, ab, to, st};
   endfunction

   // Returns every stimulus input to its idle value.
   task automatic clearInputs();
      rs1D_addr_i   = 5'd0;
      rs2D_addr_i   = 5'd0;
      rs1D_used_i   = 1'b0;
      rs2D_used_i   = 1'b0;
      rdE_addr_i    = 5'd0;
      rdE_wrt_ena_i = 1'b0;
      loadE_i       = 1'b0;
      redirect_i    = 1'b0;
      mc_req_i      = 1'b0;
      mc_done_i     = 1'b0;
   endtask

   // Puts a load in execute (writing rd) and a reader of rs1/rs2 in decode.
   task automatic setLoadUse(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic ld);
      rdE_addr_i    = rd;
      rdE_wrt_ena_i = 1'b1;
      loadE_i       = ld;
      rs1D_addr_i   = rs1;
      rs1D_used_i   = u1;
      rs2D_addr_i   = rs2;
      rs2D_used_i   = u2;
   endtask

   // Pops the oldest expectation and compares it with the DUT outputs.
   task automatic checkOutput();
      exp_t       e;
      logic [8:0] obs;
      obs = {stallF_o, stallD_o, stallE_o, flushD_o, flushE_o,
             mc_abort_o, timeout_o, state_o};
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_empty observed=%b expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.vec) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b (sF sD sE fD fE ab to st)",
                   e.tag, obs, e.vec);
         end
      end
   endtask

   // Queues an expectation for the inputs that are currently driven. Then
   // it checks mid-cycle and returns just after the next rising edge.
   task automatic applyStimulus(input string tag, input logic [8:0] vec);
      exp_t e;
      e.tag = tag;
      e.vec = vec;
      sb.push_back(e);
      @(negedge clk_i);
      checkOutput();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // Reset held while hazard-inducing inputs are present: every output is 0.
      clearInputs();
      rstn_i = 1'b0;
      redirect_i = 1'b1;
      mc_req_i   = 1'b1;
      setLoadUse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
      #2;
      applyStimulus("reset_forces_zero", mk(0,0,0,0,0,0,0,2'd0));
      rstn_i = 1'b1;
      clearInputs();
      applyStimulus("idle_after_reset", mk(0,0,0,0,0,0,0,2'd0));

      // Load-use through rs1: one bubble cycle, and the FSM stays in RUN.
      setLoadUse(5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b1);
      applyStimulus("loaduse_rs1", mk(1,1,0,0,1,0,0,2'd0));
      clearInputs();
      applyStimulus("loaduse_rs1_release", mk(0,0,0,0,0,0,0,2'd0));

      // Load-use through rs2.
      setLoadUse(5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1);
      applyStimulus("loaduse_rs2", mk(1,1,0,0,1,0,0,2'd0));
      // rs2 matches but is not read.
      setLoadUse(5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b1);
      applyStimulus("loaduse_rs2_unused", mk(0,0,0,0,0,0,0,2'd0));
      // Load to x0 never stalls.
      setLoadUse(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
      applyStimulus("load_to_x0", mk(0,0,0,0,0,0,0,2'd0));
      // Matching ALU op (not a load) does not stall.
      setLoadUse(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
      applyStimulus("non_load_match", mk(0,0,0,0,0,0,0,2'd0));
      clearInputs();

      // Redirect: the flush lasts two cycles and the state goes 0 -> 2 -> 0.
      redirect_i = 1'b1;
      applyStimulus("redirect_run", mk(0,0,0,1,1,0,0,2'd0));
      clearInputs();
      applyStimulus("redirect_flush2", mk(0,0,0,1,1,0,0,2'd2));
      applyStimulus("redirect_done", mk(0,0,0,0,0,0,0,2'd0));

      // A redirect inside FLUSH restarts the window.
      redirect_i = 1'b1;
      applyStimulus("reflush_first", mk(0,0,0,1,1,0,0,2'd0));
      applyStimulus("reflush_restart", mk(0,0,0,1,1,0,0,2'd2));
      clearInputs();
      applyStimulus("reflush_tail", mk(0,0,0,1,1,0,0,2'd2));
      applyStimulus("reflush_done", mk(0,0,0,0,0,0,0,2'd0));

      // A redirect beats a multi-cycle request. FLUSH ignores mc_req and hit.
      redirect_i = 1'b1;
      mc_req_i   = 1'b1;
      applyStimulus("redirect_over_mc", mk(0,0,0,1,1,0,0,2'd0));
      redirect_i = 1'b0;
      setLoadUse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
      applyStimulus("flush_ignores_mc_hit", mk(0,0,0,1,1,0,0,2'd2));
      clearInputs();
      applyStimulus("flush_ignore_done", mk(0,0,0,0,0,0,0,2'd0));

      // Multi-cycle op that is done on the sixth cycle: five stall cycles,
      // then no stall in the done cycle and no abort.
      mc_req_i = 1'b1;
      applyStimulus("mc_enter", mk(1,1,1,0,0,0,0,2'd0));
      for (int i = 1; i <= 4; i++) begin
         applyStimulus($sformatf("mc_wait_%0d", i), mk(1,1,1,0,0,0,0,2'd3));
      end
      mc_done_i = 1'b1;
      applyStimulus("mc_done", mk(0,0,0,0,0,0,0,2'd3));
      clearInputs();
      applyStimulus("mc_back_to_run", mk(0,0,0,0,0,0,0,2'd0));

      // Single-cycle completion in RUN: no stall.
      mc_req_i  = 1'b1;
      mc_done_i = 1'b1;
      applyStimulus("mc_single_cycle", mk(0,0,0,0,0,0,0,2'd0));

      // A multi-cycle op beats a load-use hit: full stall and no bubble.
      mc_done_i = 1'b0;
      setLoadUse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
      applyStimulus("mc_over_hit", mk(1,1,1,0,0,0,0,2'd0));
      clearInputs();
      mc_done_i = 1'b1;
      applyStimulus("mc_over_hit_done", mk(0,0,0,0,0,0,0,2'd3));
      clearInputs();

      // Timeout: done never comes, so the abort comes in cycle 8 and the
      // timeout flag stays set.
      mc_req_i = 1'b1;
      applyStimulus("to_enter", mk(1,1,1,0,0,0,0,2'd0));
      for (int i = 1; i <= 7; i++) begin
         applyStimulus($sformatf("to_wait_%0d", i), mk(1,1,1,0,0,0,0,2'd3));
      end
      to_exp = 1'b1;
      applyStimulus("to_abort", mk(0,0,0,0,1,1,to_exp,2'd3));
      clearInputs();
      applyStimulus("to_sticky_1", mk(0,0,0,0,0,0,to_exp,2'd0));
      applyStimulus("to_sticky_2", mk(0,0,0,0,0,0,to_exp,2'd0));

      // Done arrives in the timeout cycle: done wins, with no abort.
      mc_req_i = 1'b1;
      applyStimulus("dw_enter", mk(1,1,1,0,0,0,to_exp,2'd0));
      for (int i = 1; i <= 7; i++) begin
         applyStimulus($sformatf("dw_wait_%0d", i), mk(1,1,1,0,0,0,to_exp,2'd3));
      end
      mc_done_i = 1'b1;
      applyStimulus("dw_done_wins", mk(0,0,0,0,0,0,to_exp,2'd3));
      clearInputs();
      applyStimulus("dw_back_to_run", mk(0,0,0,0,0,0,to_exp,2'd0));

      // Redirect in MC_WAIT cycle 3 aborts the op and enters FLUSH.
      mc_req_i = 1'b1;
      applyStimulus("mr_enter", mk(1,1,1,0,0,0,to_exp,2'd0));
      applyStimulus("mr_wait_1", mk(1,1,1,0,0,0,to_exp,2'd3));
      applyStimulus("mr_wait_2", mk(1,1,1,0,0,0,to_exp,2'd3));
      redirect_i = 1'b1;
      applyStimulus("mr_redirect_abort", mk(0,0,0,1,1,1,to_exp,2'd3));
      clearInputs();
      applyStimulus("mr_in_flush", mk(0,0,0,1,1,0,to_exp,2'd2));

      // Reset is asserted in the middle of FLUSH: everything is 0 at once,
      // including the sticky timeout.
      rstn_i     = 1'b0;
      redirect_i = 1'b1;
      to_exp     = 1'b0;
      applyStimulus("midflush_reset", mk(0,0,0,0,0,0,0,2'd0));
      rstn_i = 1'b1;
      clearInputs();
      applyStimulus("post_reset_idle", mk(0,0,0,0,0,0,0,2'd0));
      redirect_i = 1'b1;
      applyStimulus("post_reset_redirect", mk(0,0,0,1,1,0,0,2'd0));
      clearInputs();
      applyStimulus("post_reset_flush", mk(0,0,0,1,1,0,0,2'd2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
